// File: rtl/pid_pkg.sv
// pid_pkg: shared defaults, PID/D saturation widths and a generic signed clamp.
package pid_pkg;
  localparam int ERR_W_D = 12;
  localparam int SAT_W_D = 10;
  localparam int FRWRD_W_D = 10;
  localparam int I_W_D = 15;
  localparam int D_DEPTH_D = 3;
  localparam int PID_W = 14;
  localparam int DSAT_W = 8;
  function automatic logic signed [31:0] sat_s(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    return v > hi ? hi : (v < ~hi ? ~hi : v);
  endfunction
endpackage

// File: rtl/pid_dterm.sv
// pid_dterm: derivative term over a D_DEPTH-sample history of accepted errors.
module pid_dterm import pid_pkg::*; #(
  parameter int SAT_W = SAT_W_D,
  parameter int D_DEPTH = D_DEPTH_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld,
  input  logic signed [SAT_W-1:0]  err,
  input  logic [4:0]               d_coeff,
  output logic signed [DSAT_W+5:0] d_term
);
  logic signed [SAT_W-1:0] hist [D_DEPTH];
  logic signed [DSAT_W-1:0] dsat;
  assign dsat = DSAT_W'(sat_s(32'(err) - 32'(hist[D_DEPTH-1]), DSAT_W));
  assign d_term = (DSAT_W+6)'(dsat) * (DSAT_W+6)'($signed({1'b0, d_coeff}));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < D_DEPTH; i++) hist[i] <= '0;
    end else if (vld) begin
      hist[0] <= err;
      for (int i = 1; i < D_DEPTH; i++) hist[i] <= hist[i-1];
    end
endmodule

// File: rtl/pid_param.sv
// pid_param: saturating PID heading controller driving left/right wheel speeds.
// Integrator overflow clamps when PID_ANTIWINDUP_EN is defined, otherwise the add is dropped.
module pid_param import pid_pkg::*; #(
  parameter int ERR_W = ERR_W_D,
  parameter int SAT_W = SAT_W_D,
  parameter int FRWRD_W = FRWRD_W_D,
  parameter int I_W = I_W_D,
  parameter int D_DEPTH = D_DEPTH_D
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      moving,
  input  logic                      err_vld,
  input  logic signed [ERR_W-1:0]   error,
  input  logic [FRWRD_W-1:0]        frwrd,
  input  logic [5:0]                p_coeff,
  input  logic [4:0]                d_coeff,
  output logic signed [FRWRD_W:0]   lft_spd,
  output logic signed [FRWRD_W:0]   rght_spd,
  output logic                      spd_vld,
  output logic                      i_sat
);
  localparam int PW = SAT_W + 7;
  logic signed [SAT_W-1:0] err_sat, err_q;
  logic vld_q, pid_vld;
  logic signed [I_W-1:0] integ;
  logic signed [I_W:0] i_sum;
  logic signed [I_W-7:0] i_term;
  logic signed [PW-1:0] p_prod, p_term;
  logic signed [DSAT_W+5:0] d_term;
  logic signed [PID_W-1:0] pid_n, pid_q;
  logic signed [31:0] pid_x, l_n, r_n;
  assign err_sat = SAT_W'(sat_s(32'(error), SAT_W));
  assign p_prod = PW'(err_q) * PW'($signed({1'b0, p_coeff}));
  assign p_term = p_prod >>> 1;
  assign i_term = integ[I_W-1:6];
  assign i_sum = (I_W+1)'(integ) + (I_W+1)'(err_q);
  assign pid_n = PID_W'(sat_s(32'(p_term) + 32'(i_term) + 32'(d_term), PID_W));
  assign pid_x = 32'(pid_q) >>> 3;
  assign l_n = $signed(32'(frwrd)) + pid_x;
  assign r_n = $signed(32'(frwrd)) - pid_x;
  pid_dterm #(.SAT_W(SAT_W), .D_DEPTH(D_DEPTH)) u_dterm (
    .clk(clk), .rst(rst), .vld(vld_q), .err(err_q), .d_coeff(d_coeff), .d_term(d_term)
  );
`ifdef PID_ANTIWINDUP_EN
  localparam logic signed [I_W-1:0] I_MAX = {1'b0, {(I_W-1){1'b1}}};
  localparam logic signed [I_W-1:0] I_MIN = ~I_MAX;
`endif
  // an add overflows when the extra sign bit disagrees with the result's sign
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      integ <= '0;
      i_sat <= 1'b0;
    end else if (!moving) begin
      integ <= '0;
      i_sat <= 1'b0;
    end else if (vld_q) begin
      if (i_sum[I_W] != i_sum[I_W-1]) begin
`ifdef PID_ANTIWINDUP_EN
        integ <= i_sum[I_W] ? I_MIN : I_MAX;
`else
        integ <= integ;
`endif
        i_sat <= 1'b1;
      end else begin
        integ <= i_sum[I_W-1:0];
        i_sat <= 1'b0;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_q <= '0;
      vld_q <= 1'b0;
      pid_q <= '0;
      pid_vld <= 1'b0;
      spd_vld <= 1'b0;
      lft_spd <= '0;
      rght_spd <= '0;
    end else begin
      err_q <= err_sat;
      vld_q <= err_vld;
      pid_vld <= vld_q;
      spd_vld <= pid_vld;
      if (vld_q) pid_q <= pid_n;
      lft_spd <= moving ? (FRWRD_W+1)'(sat_s(l_n, FRWRD_W + 1)) : '0;
      rght_spd <= moving ? (FRWRD_W+1)'(sat_s(r_n, FRWRD_W + 1)) : '0;
    end
endmodule

// File: tb/tb_pid_param.sv
// tb_pid_param: directed and random stimulus checked against an integer reference model.
module tb_pid_param;
  localparam int D = 3;
  localparam int IMAX = 16383;
  logic clk = 1'b0;
  logic rst, moving, err_vld;
  logic signed [11:0] error;
  logic [9:0] frwrd;
  logic [5:0] p_coeff;
  logic [4:0] d_coeff;
  logic signed [10:0] lft_spd, rght_spd;
  logic spd_vld, i_sat;
  int checks = 0, errors = 0;
  int m_errq, m_vldq, m_pvld, m_svld, m_integ, m_isat, m_pid, m_lft, m_rght;
  int hist[$];

  pid_param dut (
    .clk(clk), .rst(rst), .moving(moving), .err_vld(err_vld), .error(error),
    .frwrd(frwrd), .p_coeff(p_coeff), .d_coeff(d_coeff),
    .lft_spd(lft_spd), .rght_spd(rght_spd), .spd_vld(spd_vld), .i_sat(i_sat)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int v, input int w);
    int hi;
    hi = (1 << (w - 1)) - 1;
    return v > hi ? hi : (v < -hi - 1 ? -hi - 1 : v);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset;
    {m_errq, m_vldq, m_pvld, m_svld, m_integ, m_isat, m_pid, m_lft, m_rght} = '0;
    hist = {};
    for (int i = 0; i < D; i++) hist.push_back(0);
  endtask

  // one accepted sample: P, pre-update I and D from the sample D valid samples ago
  task automatic model_step;
    int d, s, n_integ, n_isat, n_pid;
    n_pid = m_pid;
    n_integ = m_integ;
    n_isat = m_isat;
    if (m_vldq != 0) begin
      d = clampi(m_errq - hist[D-1], 8) * int'(d_coeff);
      n_pid = clampi(((m_errq * int'(p_coeff)) >>> 1) + (m_integ >>> 6) + d, 14);
      hist.push_front(m_errq);
      void'(hist.pop_back());
    end
    if (!moving) begin
      n_integ = 0;
      n_isat = 0;
    end else if (m_vldq != 0) begin
      s = m_integ + m_errq;
      if (s > IMAX || s < -IMAX - 1) begin
        n_isat = 1;
`ifdef PID_ANTIWINDUP_EN
        n_integ = s > 0 ? IMAX : -IMAX - 1;
`endif
      end else begin
        n_integ = s;
        n_isat = 0;
      end
    end
    m_lft = moving ? clampi(int'(frwrd) + (m_pid >>> 3), 11) : 0;
    m_rght = moving ? clampi(int'(frwrd) - (m_pid >>> 3), 11) : 0;
    m_svld = m_pvld;
    m_pvld = m_vldq;
    m_vldq = int'(err_vld);
    m_errq = clampi(int'(error), 10);
    m_pid = n_pid;
    m_integ = n_integ;
    m_isat = n_isat;
  endtask

  task automatic tick;
    @(posedge clk);
    model_step();
    #1;
    chk("lft_spd", int'(lft_spd), m_lft);
    chk("rght_spd", int'(rght_spd), m_rght);
    chk("spd_vld", int'(spd_vld), m_svld);
    chk("i_sat", int'(i_sat), m_isat);
    chk("integ", int'(dut.integ), m_integ);
    chk("pid_q", int'(dut.pid_q), m_pid);
  endtask

  task automatic do_reset;
    #2 rst = 1'b1;
    #1;
    chk("rst_lft", int'(lft_spd), 0);
    chk("rst_rght", int'(rght_spd), 0);
    chk("rst_spd_vld", int'(spd_vld), 0);
    chk("rst_i_sat", int'(i_sat), 0);
    chk("rst_integ", int'(dut.integ), 0);
    chk("rst_pid_q", int'(dut.pid_q), 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    moving = 1'b0;
    err_vld = 1'b0;
    error = '0;
    frwrd = '0;
    p_coeff = 6'h10;
    d_coeff = 5'h07;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("init_lft", int'(lft_spd), 0);
    chk("init_spd_vld", int'(spd_vld), 0);
    chk("init_err_q", int'(dut.err_q), 0);
    moving = 1'b1;
    frwrd = 10'h200;
    error = 12'sd100;
    err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    tick();
    chk("single_pid", int'(dut.pid_q), 1500);
    tick();
    chk("single_lft", int'(lft_spd), 699);
    chk("single_rght", int'(rght_spd), 325);
    chk("single_vld", int'(spd_vld), 1);
    tick();
    chk("single_vld_pulse", int'(spd_vld), 0);
    error = 12'h7FF;
    err_vld = 1'b1;
    tick();
    chk("err_q_pos_sat", int'(dut.err_q), 511);
    error = 12'h800;
    tick();
    chk("err_q_neg_sat", int'(dut.err_q), -512);
    err_vld = 1'b0;
    repeat (4) tick();
    do_reset();
    moving = 1'b1;
    frwrd = 10'h3FF;
    error = 12'sd511;
    err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    tick();
    chk("max_pid", int'(dut.pid_q), 4977);
    tick();
    chk("max_lft_clamp", int'(lft_spd), 1023);
    chk("max_rght", int'(rght_spd), 401);
    do_reset();
    moving = 1'b1;
    frwrd = 10'h100;
    error = 12'sd511;
    err_vld = 1'b1;
    repeat (40) tick();
`ifdef PID_ANTIWINDUP_EN
    chk("windup_integ", int'(dut.integ), 16383);
`else
    chk("windup_integ", int'(dut.integ), 16352);
`endif
    chk("windup_i_sat", int'(i_sat), 1);
    moving = 1'b0;
    tick();
    chk("stop_integ", int'(dut.integ), 0);
    chk("stop_lft", int'(lft_spd), 0);
    chk("stop_rght", int'(rght_spd), 0);
    chk("stop_i_sat", int'(i_sat), 0);
    moving = 1'b1;
    err_vld = 1'b0;
    tick();
    for (int n = 0; n < 400; n++) begin
      moving = ($urandom_range(0, 9) != 0);
      err_vld = 1'($urandom_range(0, 1));
      error = ($urandom_range(0, 7) == 0) ? 12'h7FF : 12'($urandom);
      frwrd = 10'($urandom);
      p_coeff = 6'($urandom);
      d_coeff = 5'($urandom);
      tick();
    end
    moving = 1'b1;
    error = 12'sd300;
    err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    tick();
    do_reset();
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("post_rst_no_vld", int'(spd_vld), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
